wb_regfile: RTL and testbench

- Receiving end of the write-back control interface: consumes RFWrite / RegIn / R1WBSel plus the WB-stage instruction and data, and commits results into the architectural register file.
- Provides two decode-stage read ports with same-cycle write bypass.
- Keeps a per-register pending-write scoreboard, so decode can stall on RAW hazards against writes still in flight in the pipeline.

---
 rtl/wb_regfile.sv | 100 ++++++++++
 tb/tb_wb_regfile.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: write-back commit into the register file, bypassed decode reads and a pending-write scoreboard
module wb_regfile #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4,
   parameter int K1_IDX = 1,
   parameter int FWD    = 1,
   parameter int CNT_W  = 2,
   parameter int ADDR_W = $clog2(NREG)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              WBValid,
   input  logic              RFWrite,
   input  logic              RegIn,
   input  logic              R1WBSel,
   input  logic [7:0]        IR4,
   input  logic [DATA_W-1:0] ALUOut,
   input  logic [DATA_W-1:0] MemData,
   input  logic [ADDR_W-1:0] RdAddr1,
   input  logic [ADDR_W-1:0] RdAddr2,
   output logic [DATA_W-1:0] RdData1,
   output logic [DATA_W-1:0] RdData2,
   input  logic              IssueValid,
   input  logic [ADDR_W-1:0] IssueDest,
   input  logic              RdUse1,
   input  logic              RdUse2,
   output logic              Stall,
   output logic              SbErr
);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;
   localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);
   localparam logic             BYPASS   = (FWD != 0);

   logic              we;
   logic [ADDR_W-1:0] wa;
   logic [DATA_W-1:0] wd;
   logic              hit1, hit2, hit_iss;
   logic              haz1, haz2, full;
   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [CNT_W-1:0]  pend_q [NREG];
   logic [CNT_W-1:0]  pend_d [NREG];
   logic              retire_r [NREG];
   logic              issue_r [NREG];
   logic              sb_err_q, sb_err_d;
   logic              unused_ir4;

   assign unused_ir4 = ^IR4[7-ADDR_W:0];

   // Commit decode, bypassed reads and hazard/stall evaluation
   always_comb begin
      we      = WBValid & RFWrite;
      wa      = R1WBSel ? ADDR_W'(K1_IDX) : IR4[7 -: ADDR_W];
      wd      = RegIn ? MemData : ALUOut;
      hit1    = we & (wa == RdAddr1);
      hit2    = we & (wa == RdAddr2);
      hit_iss = we & (wa == IssueDest);
      RdData1 = (BYPASS & hit1) ? wd : regs_q[RdAddr1];
      RdData2 = (BYPASS & hit2) ? wd : regs_q[RdAddr2];
      haz1    = RdUse1 & (pend_q[RdAddr1] != '0) & ~(BYPASS & hit1 & (pend_q[RdAddr1] == PEND_ONE));
      haz2    = RdUse2 & (pend_q[RdAddr2] != '0) & ~(BYPASS & hit2 & (pend_q[RdAddr2] == PEND_ONE));
      full    = IssueValid & (pend_q[IssueDest] == PEND_MAX) & ~hit_iss;
      Stall   = haz1 | haz2 | full;
      SbErr   = sb_err_q;
   end

   // Next register and scoreboard state; a retire with nothing pending holds at zero and flags an error
   always_comb begin
      sb_err_d = sb_err_q;
      for (int r = 0; r < NREG; r++) begin
         retire_r[r] = we & (wa == ADDR_W'(r));
         issue_r[r]  = IssueValid & ~Stall & (IssueDest == ADDR_W'(r));
         regs_d[r]   = retire_r[r] ? wd : regs_q[r];
         pend_d[r]   = pend_q[r];
         if (issue_r[r] && !retire_r[r])
            pend_d[r] = pend_q[r] + PEND_ONE;
         else if (retire_r[r] && !issue_r[r]) begin
            pend_d[r] = (pend_q[r] == '0) ? '0 : pend_q[r] - PEND_ONE;
            sb_err_d  = sb_err_d | (pend_q[r] == '0);
         end
      end
   end

   // State registers with synchronous reset discarding same-cycle activity
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
            pend_q[r] <= '0;
         end
         sb_err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
            pend_q[r] <= pend_d[r];
         end
         sb_err_q <= sb_err_d;
      end
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench with a behavioural reference model for wb_regfile (bypassed and non-bypassed builds)
module tb_wb_regfile;
   logic       clock = 1'b0;
   logic       reset, WBValid, RFWrite, RegIn, R1WBSel;
   logic [7:0] IR4, ALUOut, MemData;
   logic [1:0] RdAddr1, RdAddr2, IssueDest;
   logic       IssueValid, RdUse1, RdUse2;
   logic [7:0] RdData1, RdData2, nf_rd1, nf_rd2;
   logic       Stall, SbErr, nf_stall, nf_err;

   typedef struct packed {
      logic [7:0] r1, r2, n1, n2;
      logic       st, er;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   int   m_regs [4];
   int   m_pend [4];
   bit   m_err;

   always #5 clock = ~clock;

   wb_regfile #(.FWD(1)) u_dut (
      .clock(clock), .reset(reset), .WBValid(WBValid), .RFWrite(RFWrite), .RegIn(RegIn),
      .R1WBSel(R1WBSel), .IR4(IR4), .ALUOut(ALUOut), .MemData(MemData),
      .RdAddr1(RdAddr1), .RdAddr2(RdAddr2), .RdData1(RdData1), .RdData2(RdData2),
      .IssueValid(IssueValid), .IssueDest(IssueDest), .RdUse1(RdUse1), .RdUse2(RdUse2),
      .Stall(Stall), .SbErr(SbErr));

   wb_regfile #(.FWD(0)) u_nf (
      .clock(clock), .reset(reset), .WBValid(WBValid), .RFWrite(RFWrite), .RegIn(RegIn),
      .R1WBSel(R1WBSel), .IR4(IR4), .ALUOut(ALUOut), .MemData(MemData),
      .RdAddr1(RdAddr1), .RdAddr2(RdAddr2), .RdData1(nf_rd1), .RdData2(nf_rd2),
      .IssueValid(IssueValid), .IssueDest(IssueDest), .RdUse1(RdUse1), .RdUse2(RdUse2),
      .Stall(nf_stall), .SbErr(nf_err));

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
      end
   endtask

   // Monitor: outputs are combinational, so each cycle's expectation is compared mid-cycle
   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("rd1", int'(RdData1), int'(e.r1));
         chk("rd2", int'(RdData2), int'(e.r2));
         chk("nf_rd1", int'(nf_rd1), int'(e.n1));
         chk("nf_rd2", int'(nf_rd2), int'(e.n2));
         chk("stall", int'(Stall), int'(e.st));
         chk("sberr", int'(SbErr), int'(e.er));
      end
   end

   // Reference model: predict this cycle's outputs, push them, then apply the clock edge
   task automatic step();
      bit we, stall, ret, iss;
      int wa, wd, a1, a2, d;
      exp_t e;
      we = WBValid && RFWrite;
      wa = R1WBSel ? 1 : int'(IR4) / 64;
      wd = RegIn ? int'(MemData) : int'(ALUOut);
      a1 = int'(RdAddr1);
      a2 = int'(RdAddr2);
      d  = int'(IssueDest);
      e.n1 = 8'(m_regs[a1]);
      e.n2 = 8'(m_regs[a2]);
      e.r1 = (we && wa == a1) ? 8'(wd) : e.n1;
      e.r2 = (we && wa == a2) ? 8'(wd) : e.n2;
      stall = (RdUse1 && m_pend[a1] > 0 && !(we && wa == a1 && m_pend[a1] == 1)) ||
              (RdUse2 && m_pend[a2] > 0 && !(we && wa == a2 && m_pend[a2] == 1)) ||
              (IssueValid && m_pend[d] == 3 && !(we && wa == d));
      e.st = stall;
      e.er = m_err;
      exp_q.push_back(e);
      @(posedge clock);
      if (reset) begin
         m_regs = '{0, 0, 0, 0};
         m_pend = '{0, 0, 0, 0};
         m_err  = 0;
      end else begin
         if (we) m_regs[wa] = wd;
         for (int r = 0; r < 4; r++) begin
            ret = we && wa == r;
            iss = IssueValid && !stall && d == r;
            if (iss && !ret) m_pend[r]++;
            else if (ret && !iss) begin
               if (m_pend[r] == 0) m_err = 1;
               else m_pend[r]--;
            end
         end
      end
      #1;
   endtask

   task automatic idle();
      reset = 0; WBValid = 0; RFWrite = 0; RegIn = 0; R1WBSel = 0;
      IR4 = 0; ALUOut = 0; MemData = 0; RdAddr1 = 0; RdAddr2 = 0;
      IssueValid = 0; IssueDest = 0; RdUse1 = 0; RdUse2 = 0;
   endtask

   task automatic wb(input bit r1sel, input bit regin, input logic [7:0] ir, input logic [7:0] val);
      WBValid = 1; RFWrite = 1; R1WBSel = r1sel; RegIn = regin; IR4 = ir;
      if (regin) MemData = val; else ALUOut = val;
   endtask

   initial begin
      m_regs = '{0, 0, 0, 0};
      m_pend = '{0, 0, 0, 0};
      m_err  = 0;
      idle();
      reset = 1;
      @(posedge clock); #1;
      step(); step();
      idle();
      for (int a = 0; a < 4; a++) begin
         RdAddr1 = 2'(a); RdAddr2 = 2'(3 - a); step();
      end
      // load into reg2 with same-cycle read
      wb(0, 1, 8'h80, 8'h5A); RdAddr1 = 2; step();
      idle(); RdAddr1 = 2; RdAddr2 = 2; step();
      // ori into K1 register, IR4 destination ignored
      wb(1, 0, 8'hC7, 8'h3C); RdAddr1 = 1; RdAddr2 = 3; step();
      idle(); RdAddr1 = 1; RdAddr2 = 3; step();
      // RAW hazard on reg3 resolved by bypass in the retire cycle
      IssueValid = 1; IssueDest = 3; step();
      idle(); RdUse1 = 1; RdAddr1 = 3; step(); step();
      wb(0, 0, 8'hC0, 8'h77); RdUse1 = 1; RdAddr1 = 3; step();
      idle(); RdUse1 = 1; RdAddr1 = 3; step();
      // saturate reg0 scoreboard, then issue+retire in one cycle
      idle(); IssueValid = 1; IssueDest = 0;
      repeat (4) step();
      wb(0, 0, 8'h00, 8'h11); IssueValid = 1; IssueDest = 0; step();
      idle(); IssueValid = 1; IssueDest = 0; step();
      idle(); RdUse2 = 1; RdAddr2 = 0;
      repeat (3) begin wb(0, 0, 8'h00, 8'h22); RdUse2 = 1; RdAddr2 = 0; step(); end
      idle(); RdUse2 = 1; RdAddr2 = 0; step();
      // retire with nothing pending sets sticky error
      wb(1, 0, 8'h00, 8'h44); step();
      idle(); step(); step();
      // reset during a write of 0xFF
      wb(0, 0, 8'h80, 8'hFF); IssueValid = 1; IssueDest = 2; reset = 1; step();
      idle(); RdAddr1 = 2; RdUse1 = 1; step();
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         reset      = ($urandom_range(0, 79) == 0);
         WBValid    = $urandom_range(0, 1) == 1;
         RFWrite    = $urandom_range(0, 2) != 0;
         RegIn      = 1'($urandom);
         R1WBSel    = $urandom_range(0, 3) == 0;
         IR4        = 8'($urandom);
         ALUOut     = 8'($urandom);
         MemData    = 8'($urandom);
         RdAddr1    = 2'($urandom);
         RdAddr2    = 2'($urandom);
         IssueValid = $urandom_range(0, 1) == 1;
         IssueDest  = 2'($urandom);
         RdUse1     = 1'($urandom);
         RdUse2     = 1'($urandom);
         step();
      end
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue: got=%0d want=0 entries left", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
